// File: rtl/exec_pipe_pkg.sv
// Shared types and constants for the two-stage execute unit.
// Kept free of per-instance parameters so every block can import it.
package exec_pipe_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_t;

    // Shift-amount width for a given datapath width; guards the degenerate 1-bit case.
    function automatic int shamt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    localparam int D_WIDTH_DEF = 32;
    localparam int SHAMT_W     = shamt_width(D_WIDTH_DEF);
    localparam int REG_ZERO    = 0;

endpackage

// File: rtl/exec_pipe_unit_if.sv
// Decode/control <-> execute unit bundle. master is the control side,
// slave is the execute unit.
interface exec_pipe_unit_if
    import exec_pipe_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    logic               valid_in;
    logic               ALUsrc;
    alu_op_t            ALUctrl;
    logic [D_WIDTH-1:0] ImmOp;
    logic               WE3;
    logic [A_WIDTH-1:0] AD1;
    logic [A_WIDTH-1:0] AD2;
    logic [A_WIDTH-1:0] AD3;
    logic               EQ;
    logic               valid_out;
    logic [D_WIDTH-1:0] result;
    logic [D_WIDTH-1:0] a0;

    modport master (
        output valid_in, ALUsrc, ALUctrl, ImmOp, WE3, AD1, AD2, AD3,
        input  EQ, valid_out, result, a0
    );

    modport slave (
        input  valid_in, ALUsrc, ALUctrl, ImmOp, WE3, AD1, AD2, AD3,
        output EQ, valid_out, result, a0
    );
endinterface

// File: rtl/alu_core.sv
// Combinational multi-op ALU: wrapping add/sub, bitwise ops, signed SLT
// and logical shifts using only the low shamt bits of op2.
module alu_core
    import exec_pipe_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] op1,
    input  logic [D_WIDTH-1:0] op2,
    input  alu_op_t            op,
    output logic [D_WIDTH-1:0] res
);
    localparam int SH_W = shamt_width(D_WIDTH);

    logic [SH_W-1:0] shamt;
    logic            lt;

    assign shamt = op2[SH_W-1:0];
    assign lt    = $signed(op1) < $signed(op2);

    always_comb begin
        res = '0;
        case (op)
            ALU_ADD: res = op1 + op2;
            ALU_SUB: res = op1 - op2;
            ALU_AND: res = op1 & op2;
            ALU_OR:  res = op1 | op2;
            ALU_XOR: res = op1 ^ op2;
            ALU_SLT: res = {{(D_WIDTH-1){1'b0}}, lt};
            ALU_SLL: res = op1 << shamt;
            ALU_SRL: res = op1 >> shamt;
            default: res = '0;
        endcase
    end
endmodule

// File: rtl/exec_pipe_unit.sv
// Two-stage execute unit: register read + bypass + ALU in EX, registered WB
// that commits to the register file one edge later. x0 is hardwired to zero.
module exec_pipe_unit
    import exec_pipe_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int A_WIDTH  = 5,
    parameter int A0_INDEX = 10
) (
    input  logic             clk,
    input  logic             rst,
    exec_pipe_unit_if.slave  bus
);
    localparam int                 NREG  = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] X0    = A_WIDTH'(REG_ZERO);
    localparam logic [A_WIDTH-1:0] A0_AD = A_WIDTH'(A0_INDEX);

    logic [D_WIDTH-1:0] rf [NREG];

    logic               wb_we;
    logic               wb_valid;
    logic [A_WIDTH-1:0] wb_ad3;
    logic [D_WIDTH-1:0] wb_result;
    logic               wb_commit;

    logic [D_WIDTH-1:0] rd1;
    logic [D_WIDTH-1:0] rd2;
    logic [D_WIDTH-1:0] op2;
    logic [D_WIDTH-1:0] alu_res;

    // A pending WB write to x0 is never a real write, so it must not bypass either.
    assign wb_commit = wb_we && (wb_ad3 != X0);

    always_comb begin
        rd1 = '0;
        if (bus.AD1 != X0)
            rd1 = (wb_commit && wb_ad3 == bus.AD1) ? wb_result : rf[bus.AD1];
    end

    always_comb begin
        rd2 = '0;
        if (bus.AD2 != X0)
            rd2 = (wb_commit && wb_ad3 == bus.AD2) ? wb_result : rf[bus.AD2];
    end

    assign op2    = bus.ALUsrc ? bus.ImmOp : rd2;
    assign bus.EQ = (rd1 == rd2);

    alu_core #(.D_WIDTH(D_WIDTH)) u_alu (
        .op1 (rd1),
        .op2 (op2),
        .op  (bus.ALUctrl),
        .res (alu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_result <= '0;
            wb_ad3    <= '0;
            wb_we     <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            wb_result <= alu_res;
            wb_ad3    <= bus.AD3;
            wb_we     <= bus.valid_in & bus.WE3;
            wb_valid  <= bus.valid_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (wb_commit) begin
            rf[wb_ad3] <= wb_result;
        end
    end

    assign bus.valid_out = wb_valid;
    assign bus.result    = wb_result;
    assign bus.a0        = rf[A0_AD];
endmodule

// File: tb/tb_exec_pipe_unit.sv
// Bench for exec_pipe_unit: a sequential (in-order, no-pipeline) architectural
// model predicts EQ, result/valid_out one cycle later and a0 two edges later.
module tb_exec_pipe_unit;
    import exec_pipe_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int A0 = 10;

    logic clk = 1'b0;
    logic rst;

    exec_pipe_unit_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus();

    exec_pipe_unit #(.D_WIDTH(DW), .A_WIDTH(AW), .A0_INDEX(A0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Architectural state: every issued op is applied immediately, in program order.
    logic [DW-1:0] arch [32];
    logic [DW-1:0] h1, h2, pr;
    logic          pv;

    logic          exp_valid, exp_eq;
    logic [DW-1:0] exp_result, exp_a0;

    logic          pin_res_v, pin_eq_v, pin_vo_v, pin_a0_v;
    logic [DW-1:0] pin_res, pin_a0;
    logic          pin_eq, pin_vo;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] m_alu(input alu_op_t op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
            chk("rst_result", bus.result, 32'd0);
            chk("rst_a0", bus.a0, 32'd0);
        end else begin
            chk("eq", {31'd0, bus.EQ}, {31'd0, exp_eq});
            chk("valid_out", {31'd0, bus.valid_out}, {31'd0, exp_valid});
            chk("result", bus.result, exp_result);
            chk("a0", bus.a0, exp_a0);
            if (pin_res_v) chk("pin_result", bus.result, pin_res);
            if (pin_eq_v)  chk("pin_eq", {31'd0, bus.EQ}, {31'd0, pin_eq});
            if (pin_vo_v)  chk("pin_valid_out", {31'd0, bus.valid_out}, {31'd0, pin_vo});
            if (pin_a0_v)  chk("pin_a0", bus.a0, pin_a0);
        end
    end

    task automatic clear_pins();
        pin_res_v = 1'b0; pin_eq_v = 1'b0; pin_vo_v = 1'b0; pin_a0_v = 1'b0;
        pin_res = '0; pin_a0 = '0; pin_eq = 1'b0; pin_vo = 1'b0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) arch[i] = '0;
        h1 = '0; h2 = '0; pr = '0; pv = 1'b0;
        exp_valid = 1'b0; exp_eq = 1'b1; exp_result = '0; exp_a0 = '0;
        clear_pins();
    endtask

    task automatic drive(input logic v, input logic src, input alu_op_t op, input logic [DW-1:0] imm,
                         input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        logic [DW-1:0] op1, rd2, res;
        clear_pins();
        bus.valid_in = v; bus.ALUsrc = src; bus.ALUctrl = op; bus.ImmOp = imm;
        bus.WE3 = we; bus.AD1 = a1; bus.AD2 = a2; bus.AD3 = a3;
        h2 = h1;
        h1 = arch[A0];
        exp_a0     = h2;
        exp_valid  = pv;
        exp_result = pr;
        op1    = arch[a1];
        rd2    = arch[a2];
        exp_eq = (op1 == rd2);
        res    = m_alu(op, op1, src ? imm : rd2);
        if (v && we && a3 != 5'd0) arch[a3] = res;
        pv = v;
        pr = res;
    endtask

    task automatic step(input logic v, input logic src, input alu_op_t op, input logic [DW-1:0] imm,
                        input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        @(posedge clk);
        #1;
        drive(v, src, op, imm, we, a1, a2, a3);
    endtask

    task automatic nop();
        step(1'b0, 1'b0, ALU_ADD, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, ALU_ADD, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1;
        m_reset();
        bus.valid_in = 1'b0; bus.ALUsrc = 1'b0; bus.ALUctrl = ALU_ADD; bus.ImmOp = '0;
        bus.WE3 = 1'b0; bus.AD1 = '0; bus.AD2 = '0; bus.AD3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, ALU_ADD, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Immediate chain through the bypass into a0.
        step(1'b1, 1'b1, ALU_ADD, 32'd5, 1'b1, 5'd0, 5'd0, 5'd10);
        step(1'b1, 1'b1, ALU_ADD, 32'd7, 1'b1, 5'd10, 5'd0, 5'd10);
        pin_res_v = 1'b1; pin_res = 32'd5;
        nop();
        pin_res_v = 1'b1; pin_res = 32'd12;
        nop();
        pin_a0_v = 1'b1; pin_a0 = 32'd12;

        // x0 writes dropped and never bypassed.
        step(1'b1, 1'b1, ALU_ADD, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, ALU_ADD, 32'd0, 1'b1, 5'd0, 5'd0, 5'd1);
        pin_res_v = 1'b1; pin_res = 32'hFFFF_FFFF;
        nop();
        pin_res_v = 1'b1; pin_res = 32'd0;

        // Signed compare, shift amount truncation, subtract wrap.
        step(1'b1, 1'b1, ALU_ADD, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd2);
        step(1'b1, 1'b0, ALU_SLT, 32'd0, 1'b1, 5'd2, 5'd0, 5'd3);
        nop();
        pin_res_v = 1'b1; pin_res = 32'd1;
        step(1'b1, 1'b1, ALU_ADD, 32'h8000_0000, 1'b1, 5'd0, 5'd0, 5'd6);
        step(1'b1, 1'b1, ALU_SRL, 32'h21, 1'b1, 5'd6, 5'd0, 5'd7);
        nop();
        pin_res_v = 1'b1; pin_res = 32'h4000_0000;
        step(1'b1, 1'b1, ALU_SUB, 32'd1, 1'b1, 5'd0, 5'd0, 5'd8);
        nop();
        pin_res_v = 1'b1; pin_res = 32'hFFFF_FFFF;

        // EQ from the file, then EQ flipped by a back-to-back write.
        step(1'b1, 1'b1, ALU_ADD, 32'd9, 1'b1, 5'd0, 5'd0, 5'd4);
        step(1'b1, 1'b1, ALU_ADD, 32'd9, 1'b1, 5'd0, 5'd0, 5'd5);
        nop();
        step(1'b1, 1'b1, ALU_ADD, 32'd3, 1'b1, 5'd4, 5'd5, 5'd12);
        pin_eq_v = 1'b1; pin_eq = 1'b1;
        step(1'b1, 1'b1, ALU_ADD, 32'd8, 1'b1, 5'd0, 5'd0, 5'd5);
        pin_res_v = 1'b1; pin_res = 32'd12;
        step(1'b1, 1'b1, ALU_ADD, 32'd3, 1'b1, 5'd4, 5'd5, 5'd13);
        pin_eq_v = 1'b1; pin_eq = 1'b0;

        // valid_in low with WE3 high must not write.
        step(1'b0, 1'b1, ALU_ADD, 32'd77, 1'b1, 5'd0, 5'd0, 5'd4);
        nop();
        pin_vo_v = 1'b1; pin_vo = 1'b0;
        step(1'b1, 1'b0, ALU_ADD, 32'd0, 1'b0, 5'd4, 5'd0, 5'd0);
        nop();
        pin_res_v = 1'b1; pin_res = 32'd9;

        // Reset while a WB write to x11 is in flight.
        step(1'b1, 1'b1, ALU_ADD, 32'h55, 1'b1, 5'd0, 5'd0, 5'd11);
        mid_reset();
        step(1'b1, 1'b0, ALU_ADD, 32'd0, 1'b0, 5'd11, 5'd0, 5'd0);
        nop();
        pin_res_v = 1'b1; pin_res = 32'd0;

        // Random back-to-back traffic over a small register window that includes a0.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom()),
                 ($urandom_range(0, 4) != 0), AW'($urandom_range(0, 15)),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
        end
        nop();
        nop();
        nop();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
